stream_pattern_gen: RTL and testbench
=====================================

Name: stream_pattern_gen

Overview:
Parametrised periodic test-pattern source driving a valid/ready stream. Every PERIOD clocks it emits a burst of BURST words. Pattern is runtime-selectable: modulo counter, Galois LFSR, walking one, or alternating 0101/1010. Feeds UART TX and FIFO benches as a drop-in, richer generator.

Parameters:
W, 8, data width in bits (>=2, even).
PERIOD, 50000000, idle clocks between bursts (>=1).
BURST, 1, handshakes per burst (>=1).
MOD, 10, counter-mode modulus (1..2^W).
LFSR_TAPS, 8'hB8, Galois tap mask, W bits.
LFSR_SEED, 8'h01, LFSR start value, W bits, nonzero.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low (asserted when 0)
enable  in  1  run request
mode  in  2  0=counter, 1=LFSR, 2=walking one, 3=alternating
data  out  W  stream payload
valid  out  1  payload valid
ready  in  1  sink accepts
busy  out  1  high in SEND state
words_sent  out  32  handshake count, wraps at 2^32

Behaviour:
- Reset (rst=0, async): state IDLE; valid=0; busy=0; data=0; words_sent=0; timer=0; burst count=0; latched mode=0. Outputs clear immediately, not at the next edge.
- Handshake: a transfer occurs on any edge with valid&ready.
  - Once valid=1, data and valid hold stable until the transfer.
  - valid never drops without a transfer, except on reset.
- FSM states:
  - IDLE: enable=1 -> WAIT with timer=0.
  - WAIT: timer increments each clock. When timer=PERIOD-1 -> SEND.
    - On entry to SEND: latch mode. If the latched mode differs from the previous one, or this is the first burst since reset, load that mode's initial value into data. valid=1 and busy=1 from the first SEND cycle.
    - First valid therefore occurs PERIOD+1 edges after enable is sampled high in IDLE.
    - enable=0 while in WAIT -> IDLE; timer cleared.
  - SEND: on each transfer, words_sent+1, burst count+1, data advances to the next pattern value.
    - After the BURST-th transfer -> WAIT, timer=0, burst count=0, valid=0 the next cycle.
    - If enable=0 at a transfer edge -> IDLE, burst abandoned, valid=0.
    - enable=0 with no transfer has no effect; the pending word stays valid.
- Initial values: counter 0; LFSR LFSR_SEED; walking one 1; alternating 0101...01.
- Next value:
  - counter: d==MOD-1 ? 0 : d+1.
  - LFSR: (d>>1) ^ (d[0] ? LFSR_TAPS : 0).
  - walking one: rotate left 1; MSB wraps to bit 0.
  - alternating: ~d.
- Pattern state persists across bursts and across IDLE while mode is unchanged. There is no restart on re-enable.
- mode changes mid-burst are ignored until the next SEND entry.
- ready is ignored outside SEND. An out-of-range parameter is an elaboration error.

Test Plan:
- W=8, PERIOD=4, BURST=3, MOD=5, mode=0, ready=1, enable=1 -> data 0,1,2 on consecutive cycles with valid=1; valid=0 for exactly 4 cycles; then 3,4,0; words_sent=6.
- Same config, ready=0 for 5 cycles after the first valid -> valid stays 1, data stays 0, words_sent stays 0; on ready=1, data 0 then 1,2 transfer; burst completes normally.
- mode=1, TAPS=0xB8, SEED=0x01, BURST=4 -> 0x01, 0xB8, 0x5C, 0x2E; next burst continues at 0x17.
- mode=2, BURST=9 -> 0x01, 0x02, ..., 0x80, 0x01 (wrap). mode=3, BURST=2 -> 0x55, 0xAA.
- enable dropped during SEND with ready=0 -> valid held until ready=1; one transfer; then IDLE, valid=0, busy=0. Re-enable -> the next burst resumes the pattern (counter continues from the last value+1).
- rst=0 asserted mid-SEND between clock edges -> valid, busy, data, words_sent read 0 before the next edge. After release with enable=1 -> first valid PERIOD+1 edges later with data=0.

Source files
------------

// File: rtl/stream_pattern_gen.sv
// Periodic burst pattern source on a valid/ready stream: counter, Galois LFSR,
// walking one or alternating bits, selected at runtime and latched per burst.
module stream_pattern_gen #(
    parameter int             W         = 8,
    parameter int             PERIOD    = 50000000,
    parameter int             BURST     = 1,
    parameter int             MOD       = 10,
    parameter logic [W-1:0]   LFSR_TAPS = W'(8'hB8),
    parameter logic [W-1:0]   LFSR_SEED = W'(8'h01)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic [1:0]   mode,
    output logic [W-1:0] data,
    output logic         valid,
    input  logic         ready,
    output logic         busy,
    output logic [31:0]  words_sent
);
    localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [TW-1:0] T_LAST  = TW'(PERIOD - 1);
    localparam logic [BW-1:0] B_LAST  = BW'(BURST - 1);
    localparam logic [W:0]    MOD_M1  = (W+1)'(MOD - 1);
    localparam logic [W-1:0]  ALT_INI = {(W/2){2'b01}};

    if (W < 2 || (W % 2) != 0 || PERIOD < 1 || BURST < 1 || MOD < 1 ||
        longint'(MOD) > (longint'(1) << W) || LFSR_SEED == '0) begin : g_bad_param
        $error("stream_pattern_gen: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, WAIT, SEND} state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [BW-1:0] burst_cnt;
    logic [1:0]    cur_mode;
    logic          first;

    function automatic logic [W-1:0] init_val(input logic [1:0] m);
        case (m)
            2'd0:    init_val = '0;
            2'd1:    init_val = LFSR_SEED;
            2'd2:    init_val = W'(1);
            default: init_val = ALT_INI;
        endcase
    endfunction

    function automatic logic [W-1:0] next_val(input logic [1:0] m, input logic [W-1:0] d);
        case (m)
            2'd0:    next_val = ({1'b0, d} == MOD_M1) ? '0 : d + W'(1);
            2'd1:    next_val = (d >> 1) ^ (d[0] ? LFSR_TAPS : '0);
            2'd2:    next_val = {d[W-2:0], d[W-1]};
            default: next_val = ~d;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            timer      <= '0;
            burst_cnt  <= '0;
            cur_mode   <= 2'd0;
            first      <= 1'b1;
            data       <= '0;
            valid      <= 1'b0;
            busy       <= 1'b0;
            words_sent <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= WAIT;
                        timer <= '0;
                    end
                end
                WAIT: begin
                    if (!enable) begin
                        state <= IDLE;
                        timer <= '0;
                    end else if (timer == T_LAST) begin
                        state    <= SEND;
                        valid    <= 1'b1;
                        busy     <= 1'b1;
                        cur_mode <= mode;
                        first    <= 1'b0;
                        // Pattern state survives idle gaps unless the mode changed
                        if (first || mode != cur_mode)
                            data <= init_val(mode);
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                SEND: begin
                    if (valid && ready) begin
                        words_sent <= words_sent + 32'd1;
                        data       <= next_val(cur_mode, data);
                        if (!enable || burst_cnt == B_LAST) begin
                            state     <= enable ? WAIT : IDLE;
                            timer     <= '0;
                            burst_cnt <= '0;
                            valid     <= 1'b0;
                            busy      <= 1'b0;
                        end else begin
                            burst_cnt <= burst_cnt + BW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stream_pattern_gen.sv
// Directed checks of stream_pattern_gen with W=8, PERIOD=4, BURST=3, MOD=5.
module tb_stream_pattern_gen;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [7:0]  data;
    logic        valid;
    logic        ready = 1'b0;
    logic        busy;
    logic [31:0] words_sent;

    int errors = 0;
    int checks = 0;
    logic [7:0] cap [32];
    int ncap;

    stream_pattern_gen #(.W(8), .PERIOD(4), .BURST(3), .MOD(5),
                         .LFSR_TAPS(8'hB8), .LFSR_SEED(8'h01)) dut (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .data(data),
        .valid(valid), .ready(ready), .busy(busy), .words_sent(words_sent)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns the number of edges taken until valid is seen (capped at 50).
    task automatic wait_valid(output int n);
        n = 0;
        while (!valid && n < 50) begin
            step();
            n++;
        end
    endtask

    task automatic collect(input int n);
        ncap = 0;
        for (int c = 0; c < 300 && ncap < n; c++) begin
            if (valid) begin
                cap[ncap] = data;
                ncap++;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %0h expected 0", data); end
        checks++; if (words_sent !== 32'd0) begin errors++; $display("FAIL reset_words: got %0d expected 0", words_sent); end
        step();
    endtask

    task automatic test_counter();
        int n;
        mode = 2'd0; ready = 1'b1; enable = 1'b1; rst = 1'b1;
        wait_valid(n);
        checks++; if (n !== 5) begin errors++; $display("FAIL cnt_first_latency: got %0d edges expected 5", n); end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (valid !== 1'b1 || busy !== 1'b1 || data !== 8'(k)) begin
                errors++; $display("FAIL cnt_burst1[%0d]: got v=%0b b=%0b d=%0h expected v=1 b=1 d=%0h", k, valid, busy, data, k);
            end
            step();
        end
        n = 0;
        while (!valid && n < 20) begin
            n++;
            step();
        end
        checks++; if (n !== 4) begin errors++; $display("FAIL cnt_gap: got %0d idle cycles expected 4", n); end
        for (int k = 0; k < 3; k++) begin
            logic [7:0] e;
            e = (k == 2) ? 8'd0 : 8'(3 + k);
            checks++;
            if (valid !== 1'b1 || data !== e) begin
                errors++; $display("FAIL cnt_burst2[%0d]: got v=%0b d=%0h expected v=1 d=%0h", k, valid, data, e);
            end
            step();
        end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL cnt_end_valid: got %0b expected 0", valid); end
        checks++; if (words_sent !== 32'd6) begin errors++; $display("FAIL cnt_words: got %0d expected 6", words_sent); end
    endtask

    task automatic test_backpressure();
        int n;
        rst = 1'b0;
        step();
        ready = 1'b0; rst = 1'b1;
        wait_valid(n);
        checks++; if (n !== 5) begin errors++; $display("FAIL bp_latency: got %0d edges expected 5", n); end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (valid !== 1'b1 || data !== 8'h00 || words_sent !== 32'd0) begin
                errors++; $display("FAIL bp_hold[%0d]: got v=%0b d=%0h w=%0d expected v=1 d=0 w=0", k, valid, data, words_sent);
            end
            step();
        end
        ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (valid !== 1'b1 || data !== 8'(k)) begin
                errors++; $display("FAIL bp_xfer[%0d]: got v=%0b d=%0h expected v=1 d=%0h", k, valid, data, k);
            end
            step();
        end
        checks++;
        if (valid !== 1'b0 || words_sent !== 32'd3) begin
            errors++; $display("FAIL bp_done: got v=%0b w=%0d expected v=0 w=3", valid, words_sent);
        end
    endtask

    task automatic test_lfsr();
        logic [7:0] e [6] = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};
        mode = 2'd1;
        collect(6);
        checks++; if (ncap !== 6) begin errors++; $display("FAIL lfsr_count: got %0d words expected 6", ncap); end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (cap[k] !== e[k]) begin errors++; $display("FAIL lfsr[%0d]: got %0h expected %0h", k, cap[k], e[k]); end
        end
    endtask

    task automatic test_walk();
        logic [7:0] e [9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
        mode = 2'd2;
        collect(9);
        checks++; if (ncap !== 9) begin errors++; $display("FAIL walk_count: got %0d words expected 9", ncap); end
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (cap[k] !== e[k]) begin errors++; $display("FAIL walk[%0d]: got %0h expected %0h", k, cap[k], e[k]); end
        end
    endtask

    task automatic test_alternating();
        logic [7:0] e [3] = '{8'h55, 8'hAA, 8'h55};
        mode = 2'd3;
        collect(3);
        checks++; if (ncap !== 3) begin errors++; $display("FAIL alt_count: got %0d words expected 3", ncap); end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (cap[k] !== e[k]) begin errors++; $display("FAIL alt[%0d]: got %0h expected %0h", k, cap[k], e[k]); end
        end
        checks++; if (words_sent !== 32'd21) begin errors++; $display("FAIL alt_words: got %0d expected 21", words_sent); end
    endtask

    task automatic test_enable_drop();
        int n;
        mode = 2'd0; ready = 1'b0;
        wait_valid(n);
        checks++; if (valid !== 1'b1 || data !== 8'h00) begin errors++; $display("FAIL drop_start: got v=%0b d=%0h expected v=1 d=0", valid, data); end
        enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (valid !== 1'b1 || busy !== 1'b1 || data !== 8'h00) begin
                errors++; $display("FAIL drop_hold[%0d]: got v=%0b b=%0b d=%0h expected v=1 b=1 d=0", k, valid, busy, data);
            end
        end
        ready = 1'b1;
        step();
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0 || words_sent !== 32'd22) begin
            errors++; $display("FAIL drop_idle: got v=%0b b=%0b w=%0d expected v=0 b=0 w=22", valid, busy, words_sent);
        end
        step(); step();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL drop_stays_idle: got %0b expected 0", valid); end
        enable = 1'b1;
        wait_valid(n);
        checks++; if (n !== 5) begin errors++; $display("FAIL drop_relatency: got %0d edges expected 5", n); end
        checks++; if (data !== 8'h01) begin errors++; $display("FAIL drop_resume: got %0h expected 1", data); end
    endtask

    task automatic test_async_reset();
        int n;
        ready = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0 || data !== 8'h00 || words_sent !== 32'd0) begin
            errors++; $display("FAIL async_rst: got v=%0b b=%0b d=%0h w=%0d expected all 0", valid, busy, data, words_sent);
        end
        step();
        rst = 1'b1; enable = 1'b1; ready = 1'b1; mode = 2'd0;
        wait_valid(n);
        checks++; if (n !== 5) begin errors++; $display("FAIL async_latency: got %0d edges expected 5", n); end
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL async_data: got %0h expected 0", data); end
    endtask

    initial begin
        test_reset();
        test_counter();
        test_backpressure();
        test_lfsr();
        test_walk();
        test_alternating();
        test_enable_drop();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
